dmem_responder: RTL

//  Responder end of the CPU data-memory port: services the load/store requests the pipelined core issues from its MEM stage.

---
 rtl/dmem_responder_pkg.sv | 18 +
 rtl/dmem_responder_lane_align.sv | 50 +++++
 rtl/dmem_responder.sv | 123 ++++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: access size/sign codes and MMIO word offsets.
package dmem_responder_pkg;

    typedef enum logic [2:0] {
        DM_WORD   = 3'b000,
        DM_HALF   = 3'b001,
        DM_HALF_U = 3'b010,
        DM_BYTE   = 3'b011,
        DM_BYTE_U = 3'b100
    } dm_type_e;

    // Word index within the 16-byte MMIO window (addr[3:2]).
    localparam logic [1:0] MMIO_GPIO    = 2'd0;
    localparam logic [1:0] MMIO_CYCLE   = 2'd1;
    localparam logic [1:0] MMIO_STCNT   = 2'd2;
    localparam logic [1:0] MMIO_ERRADDR = 2'd3;

endpackage

// File: rtl/dmem_responder_lane_align.sv
// Lane steering for sub-word accesses: byte enables, replicated store data, extended load data, alignment check.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
module dm_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [2:0]  dm_type,
    input  logic [1:0]  byte_off,
    input  logic [31:0] din,
    input  logic [31:0] rdword,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] dout_ext,
    output logic        misaligned
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = rdword[{byte_off, 3'b000} +: 8];
    assign lane_h = byte_off[1] ? rdword[31:16] : rdword[15:0];

    always_comb begin
        be         = 4'b0000;
        wdata      = din;
        dout_ext   = 32'h0;
        misaligned = 1'b0;
        case (dm_type)
            DM_WORD: begin
                be         = 4'b1111;
                dout_ext   = rdword;
                misaligned = (byte_off != 2'b00);
            end
            DM_HALF, DM_HALF_U: begin
                be         = byte_off[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{din[15:0]}};
                dout_ext   = (dm_type == DM_HALF) ? {{16{lane_h[15]}}, lane_h} : {16'h0, lane_h};
                misaligned = byte_off[0];
            end
            DM_BYTE, DM_BYTE_U: begin
                be       = 4'b0001 << byte_off;
                wdata    = {4{din[7:0]}};
                dout_ext = (dm_type == DM_BYTE) ? {{24{lane_b[7]}}, lane_b} : {24'h0, lane_b};
            end
            // Undefined size codes are rejected like a misaligned access.
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with byte/half/word access plus GPIO, cycle, store-count and error-capture MMIO.
// Latency: loads return combinationally in the request cycle; stores and register updates commit on the rising edge.
// Backpressure: none; every request is serviced in the cycle it is presented.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h0000_F000,
    parameter int          GPIO_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_w,
    input  logic              mem_r,
    input  logic [31:0]       addr,
    input  logic [31:0]       din,
    input  logic [2:0]        dm_type,
    output logic [31:0]       dout,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              misalign_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0] ram [DEPTH_WORDS];

    logic [31:0] cycle_cnt;
    logic [31:0] store_cnt;
    logic [31:0] err_addr;

    logic [AW-1:0] word_idx;
    logic [31:0]   rdword;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [31:0]   dout_ext;
    logic          misaligned;
    logic          ram_hit;
    logic          mmio_hit;
    logic          access_err;
    logic          ram_store;
    logic          mmio_store;
    logic          err_clear;
    logic [31:0]   mmio_rdata;

    assign word_idx = addr[AW+1:2];
    assign rdword   = ram[word_idx];
    assign ram_hit  = ({2'b00, addr[31:2]} < 32'(DEPTH_WORDS));
    assign mmio_hit = (addr[31:4] == MMIO_BASE[31:4]);

    dm_lane_align u_align (
        .dm_type    (dm_type),
        .byte_off   (addr[1:0]),
        .din        (din),
        .rdword     (rdword),
        .be         (be),
        .wdata      (wdata),
        .dout_ext   (dout_ext),
        .misaligned (misaligned)
    );

    // Out-of-range requests are silently ignored, so errors only count on a decoded hit.
    assign access_err = (mem_w || mem_r) && (ram_hit || mmio_hit) &&
                        (misaligned || (mmio_hit && (dm_type != DM_WORD)));
    assign ram_store  = mem_w && ram_hit && !access_err;
    assign mmio_store = mem_w && mmio_hit && !access_err;
    // Any write aimed at ERRADDR clears; an error raised by that same write takes precedence below.
    assign err_clear  = mem_w && mmio_hit && (addr[3:2] == MMIO_ERRADDR);

    always_comb begin
        mmio_rdata = 32'h0;
        case (addr[3:2])
            MMIO_GPIO:    mmio_rdata = {{(32-GPIO_W){1'b0}}, gpio_out};
            MMIO_CYCLE:   mmio_rdata = cycle_cnt;
            MMIO_STCNT:   mmio_rdata = store_cnt;
            MMIO_ERRADDR: mmio_rdata = err_addr;
            default:      mmio_rdata = 32'h0;
        endcase
    end

    always_comb begin
        dout = 32'h0;
        if (mem_r && !access_err) begin
            if (ram_hit)
                dout = dout_ext;
            else if (mmio_hit)
                dout = mmio_rdata;
        end
    end

    // RAM has no reset of its contents, but reset still blocks a same-cycle store.
    always_ff @(posedge clk) begin
        if (!reset && ram_store) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i])
                    ram[word_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_out     <= '0;
            cycle_cnt    <= 32'h0;
            store_cnt    <= 32'h0;
            misalign_err <= 1'b0;
            err_addr     <= 32'h0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (ram_store)
                store_cnt <= store_cnt + 32'd1;
            if (mmio_store && (addr[3:2] == MMIO_GPIO))
                gpio_out <= din[GPIO_W-1:0];
            if (access_err) begin
                misalign_err <= 1'b1;
                if (!misalign_err || err_clear)
                    err_addr <= addr;
            end else if (err_clear) begin
                misalign_err <= 1'b0;
            end
        end
    end

endmodule
